// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared types for the LC-3b cache: write-mode encoding,
//               flush sequencer states and default way-array geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // Default geometry of one cache way.
  localparam int DEF_NUM_SETS = 8;
  localparam int DEF_TAG_W    = 9;
  localparam int DEF_LINE_W   = 128;

  // Tag and physical-memory line types for the default configuration.
  typedef logic [DEF_TAG_W-1:0]  lc3b_cache_tag;
  typedef logic [DEF_LINE_W-1:0] lc3b_pmem_line;

  // Write modes applied to the addressed line on set_load.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    STORE = 2'd1,
    CLEAN = 2'd2,
    INVAL = 2'd3
  } lc3b_cache_wtype;

  // Flush sequencer states.
  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_SCAN = 2'd1,
    FL_WB   = 2'd2,
    FL_DONE = 2'd3
  } flush_state_t;

  // True for the write modes that replace tag and data contents.
  function automatic logic writes_line(input lc3b_cache_wtype wt);
    return (wt == FILL) || (wt == STORE);
  endfunction

endpackage : lc3b_types
`default_nettype wire

// File: rtl/cache_flush_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_flush_fsm
// Description : Flush sequencer for one cache way. Walks every line from 0 to
//               NUM_SETS-1, offers valid+dirty lines on the write-back port
//               and reports when a handshake should clear the dirty bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_flush_fsm
  import lc3b_types::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic             line_dirty,  // valid & dirty of line at ptr
  input  logic             wb_ready,
  output logic             idle,        // storage may accept writes
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  output logic             wb_accept,   // handshake this edge: clear dirty[ptr]
  output logic [IDX_W-1:0] ptr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  flush_state_t     state;
  flush_state_t     state_next;
  logic [IDX_W-1:0] ptr_next;

  // State and line pointer registers; reset aborts any flush in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FL_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state, pointer advance and Moore-style status outputs.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    idle       = 1'b0;
    flush_busy = 1'b1;
    flush_done = 1'b0;
    wb_valid   = 1'b0;
    wb_accept  = 1'b0;
    case (state)
      FL_IDLE: begin
        idle       = 1'b1;
        flush_busy = 1'b0;
        if (flush_req) begin
          state_next = FL_SCAN;
          ptr_next   = '0;
        end
      end
      FL_SCAN: begin
        if (line_dirty) begin
          state_next = FL_WB;
        end else if (ptr == LAST_IDX) begin
          state_next = FL_DONE;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      FL_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          wb_accept = 1'b1;
          // The pointer never wraps: the last line ends the walk.
          if (ptr == LAST_IDX) begin
            state_next = FL_DONE;
          end else begin
            ptr_next   = ptr + 1'b1;
            state_next = FL_SCAN;
          end
        end
      end
      FL_DONE: begin
        flush_done = 1'b1;
        state_next = FL_IDLE;
      end
      default: begin
        state_next = FL_IDLE;
      end
    endcase
  end

endmodule : cache_flush_fsm
`default_nettype wire

// File: rtl/cache_way_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_way_array
// Description : One cache way: per-line valid/dirty/tag/data storage with
//               combinational read, FILL/STORE/CLEAN/INVAL writes (byte-masked
//               STORE merge) and a flush sequencer with valid/ready write-back.
//               Optional macro CACHE_WAY_PARITY_EN adds per-line even parity
//               over {tag,data} and a par_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int LINE_W   = DEF_LINE_W,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int MASK_W  = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  output logic              out_valid,
  output logic              out_dirty,
  output logic [TAG_W-1:0]  out_tag,
  output logic [LINE_W-1:0] out_data,
  input  logic              set_load,
  input  logic [1:0]        write_type,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [LINE_W-1:0] in_data,
  input  logic [MASK_W-1:0] in_mask,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [IDX_W-1:0]  wb_index,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [LINE_W-1:0] wb_data
`ifdef CACHE_WAY_PARITY_EN
  ,
  output logic              par_err
`endif
);

  // Line state; valid/dirty are reset, tag/data/parity are not.
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  lc3b_cache_wtype     wtype;
  logic                idle;
  logic                write_en;
  logic                wb_accept;
  logic                line_dirty;
  logic [IDX_W-1:0]    ptr;
  logic [LINE_W-1:0]   merged_data;
  logic [LINE_W-1:0]   store_data;

  assign wtype    = lc3b_cache_wtype'(write_type);
  // Writes are only honoured while the sequencer is idle, so the write-back
  // outputs stay stable for the whole of a flush.
  assign write_en = set_load & idle;

  // Byte-masked merge of the incoming store over the currently stored line.
  for (genvar b = 0; b < MASK_W; b++) begin : g_byte_merge
    assign merged_data[8*b +: 8] = in_mask[b] ? in_data[8*b +: 8]
                                              : data_mem[index][8*b +: 8];
  end

  // FILL replaces the whole line; STORE uses the merged bytes.
  assign store_data = (wtype == STORE) ? merged_data : in_data;

  // Tag/data arrays are written only by FILL and STORE.
  always_ff @(posedge clk) begin
    if (write_en && writes_line(wtype)) begin
      tag_mem[index]  <= in_tag;
      data_mem[index] <= store_data;
    end
  end

  // Valid/dirty updates from writes and from write-back handshakes; a
  // handshake coinciding with reset is dropped by the reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (write_en) begin
        case (wtype)
          FILL: begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
          end
          STORE: begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b1;
          end
          CLEAN: begin
            dirty_q[index] <= 1'b0;
          end
          INVAL: begin
            valid_q[index] <= 1'b0;
            dirty_q[index] <= 1'b0;
          end
          default: begin
          end
        endcase
      end
      if (wb_accept) begin
        dirty_q[ptr] <= 1'b0;
      end
    end
  end

  // Combinational lookup port.
  assign out_valid = valid_q[index];
  assign out_dirty = dirty_q[index];
  assign out_tag   = tag_mem[index];
  assign out_data  = data_mem[index];

  // Write-back port always reflects the line under the flush pointer.
  assign line_dirty = valid_q[ptr] & dirty_q[ptr];
  assign wb_index   = ptr;
  assign wb_tag     = tag_mem[ptr];
  assign wb_data    = data_mem[ptr];

  cache_flush_fsm #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W)
  ) u_flush_fsm (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .line_dirty (line_dirty),
    .wb_ready   (wb_ready),
    .idle       (idle),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .wb_valid   (wb_valid),
    .wb_accept  (wb_accept),
    .ptr        (ptr)
  );

`ifdef CACHE_WAY_PARITY_EN
  logic [NUM_SETS-1:0] par_mem;

  // Even parity over {tag,data} as written, including merged store bytes.
  always_ff @(posedge clk) begin
    if (write_en && writes_line(wtype)) begin
      par_mem[index] <= ^{in_tag, store_data};
    end
  end

  // Lookup-port check, plus a check of the line being offered for write-back.
  assign par_err = (out_valid & (par_mem[index] != ^{out_tag, out_data}))
                 | (wb_valid  & (par_mem[ptr]   != ^{wb_tag,  wb_data}));
`endif

endmodule : cache_way_array
`default_nettype wire

// File: doc/cache_way_array.md
Name: cache_way_array

Overview:
- Parametrised successor to the single-way cache set storage: one way of tag/valid/dirty/data storage with configurable depth and widths.
- Adds byte-masked store merges and explicit clean/invalidate write modes.
- Adds a flush sequencer that walks every line and hands dirty lines out over a valid/ready write-back port.
- Sits under the cache controller, which arbitrates between the datapath and physical memory.

Parameters:
- NUM_SETS, 8, number of lines (power of 2, >= 2); IDX_W = log2(NUM_SETS).
- TAG_W, 9, tag width.
- LINE_W, 128, line width in bits (multiple of 8); MASK_W = LINE_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- index  in  IDX_W  lookup/write line select
- out_valid  out  1  valid[index], combinational
- out_dirty  out  1  dirty[index], combinational
- out_tag  out  TAG_W  tag[index], combinational
- out_data  out  LINE_W  data[index], combinational
- set_load  in  1  write strobe
- write_type  in  2  lc3b_cache_wtype: FILL=0, STORE=1, CLEAN=2, INVAL=3
- in_tag  in  TAG_W  write tag
- in_data  in  LINE_W  write data
- in_mask  in  MASK_W  byte enables (STORE only)
- flush_req  in  1  start flush (level sampled in IDLE)
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush completion
- wb_valid  out  1  write-back line offered
- wb_ready  in  1  write-back accepted
- wb_index  out  IDX_W  write-back line index
- wb_tag  out  TAG_W  write-back tag
- wb_data  out  LINE_W  write-back data

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - All valid and dirty bits go to 0.
  - Tag and data are not reset.
  - flush_busy, flush_done and wb_valid go to 0; FSM goes to IDLE.
  - Reset mid-flush aborts immediately: wb_valid drops the next edge and no handshake completes.
- Read: out_* are purely combinational from index, in every state.
- Writes take effect at the clk edge when set_load=1 and the FSM is in IDLE. set_load is ignored while flush_busy.
  - FILL: valid=1, dirty=0, tag=in_tag, data=in_data. Mask is ignored.
  - STORE: valid=1, dirty=1, tag=in_tag. For each byte b, data byte b takes in_data byte b if in_mask[b], else keeps its old value. A mask of 0 still sets dirty.
  - CLEAN: dirty=0. Tag, data and valid are unchanged.
  - INVAL: valid=0, dirty=0. Tag and data are unchanged.
- FSM states: IDLE, SCAN, WB, DONE; internal pointer ptr is IDX_W bits.
  - IDLE: flush_req=1 -> SCAN with ptr=0, flush_busy=1 from the next cycle. A write and flush_req in the same cycle: the write lands first and the flush sees it.
  - SCAN: if valid[ptr]&dirty[ptr] -> WB. Else, if ptr==NUM_SETS-1 -> DONE, otherwise ptr++.
  - WB:
    - wb_valid=1; wb_index=ptr, wb_tag=tag[ptr], wb_data=data[ptr], held stable until handshake.
    - Handshake is wb_valid&wb_ready at an edge; it clears dirty[ptr] (valid is kept).
    - After handshake: if ptr==NUM_SETS-1 -> DONE, else ptr++ and -> SCAN.
    - wb_ready while not in WB is ignored.
  - DONE: flush_done=1 for exactly one cycle, flush_busy=1 -> IDLE.
- Flush latency:
  - All clean: flush_busy is high NUM_SETS+1 cycles.
  - Each dirty line adds 1 + (cycles waiting on wb_ready).
  - wb_ready held high adds exactly 1 cycle per dirty line.
- flush_req while busy is ignored. flush_req held high through DONE starts a new flush from IDLE the next cycle.
- The pointer never wraps: a flush terminates after line NUM_SETS-1.

Optional Feature:
- CACHE_WAY_PARITY_EN defined:
  - Adds output par_err (1 bit) and one even-parity bit per line over {tag,data}.
  - Parity is computed on every FILL/STORE write, including the merged data.
  - par_err = out_valid & (stored parity != recomputed parity of out_tag/out_data), combinational.
  - During WB, the parity of the offered line is also checked; a mismatch holds par_err=1.
- Undefined: no parity storage and no par_err port.

Decomposition:
- lc3b_types package gets:
  - lc3b_cache_wtype enum (FILL/STORE/CLEAN/INVAL);
  - default constants for NUM_SETS/TAG_W/LINE_W;
  - existing lc3b_cache_tag/lc3b_pmem_line for the default configuration.
- One sub-module: cache_flush_fsm (state, ptr, wb handshake, flush_done), driving dirty-clear and ptr to the storage.

Test Plan:
1. Reset, then FILL idx3 tag 0x1A5 data 0xAA..AA -> out_valid=1, out_dirty=0, out_tag=0x1A5 at index=3.
2. STORE idx3 in_data all 0x55, mask 0x0001 -> data[3]=0xAA..AA55, dirty=1; CLEAN idx3 -> dirty=0, data unchanged.
3. Flush with no dirty lines, NUM_SETS=8 -> flush_busy high 9 cycles, flush_done single pulse, wb_valid never 1.
4. Dirty lines 2 and 7, wb_ready low 3 cycles on the first offer -> wb_index=2 held stable 3 cycles, then 7; both dirty=0 after, valid=1; flush_done after line 7.
5. set_load STORE idx5 and flush_req in the same cycle -> line 5 is written back in that flush; set_load during busy -> no change.
6. rst asserted while in WB -> next cycle wb_valid=0, flush_busy=0, all valid=0; with CACHE_WAY_PARITY_EN, a forced data bit flip on a valid line -> par_err=1.
